mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/arb_rr_pick.sv | 18 +
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

    localparam logic [31:0]  BUS_ERR_DATA           = 32'hDEADBEEF;
    localparam int unsigned  DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin choice between two requesters.
// A single request always wins; on a tie the master not served last wins.
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_m1,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_m1 ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter with round-robin grant.
// Define MEM_ARBITER_TIMEOUT_EN to compile in the slave-response watchdog and sticky err flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_async,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        err
);

    arb_state_e state_q, state_d;
    logic       last_m1_q, last_m1_d;
    logic [1:0] pick;
    logic       cur_valid;
    logic       expire;

    arb_rr_pick u_pick (
        .req     ({m1_valid, m0_valid}),
        .last_m1 (last_m1_q),
        .pick    (pick)
    );

    assign cur_valid = (state_q == StGrant0) ? m0_valid :
                       (state_q == StGrant1) ? m1_valid : 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q;

    // An aborted request (valid dropped) never reports a timeout.
    assign expire = cur_valid && !s_ready && (cnt_q == CNT_LIMIT);

    always_comb begin
        cnt_d = 16'd0;
        if (state_q != StIdle && !s_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | expire;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            state_q   <= StIdle;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        unique case (state_q)
            StIdle: begin
                if (pick[0]) begin
                    state_d = StGrant0;
                end else if (pick[1]) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (!cur_valid) begin
                    state_d = StIdle;
                end else if (s_ready || expire) begin
                    state_d   = StIdle;
                    last_m1_d = (state_q == StGrant1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = 32'd0;
        s_wdata  = 32'd0;
        s_wstrb  = 4'd0;
        m0_ready = 1'b0;
        m0_rdata = 32'd0;
        m1_ready = 1'b0;
        m1_rdata = 32'd0;
        grant    = 2'b00;
        unique case (state_q)
            StGrant0: begin
                grant    = 2'b01;
                s_valid  = m0_valid && !expire;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready || expire;
                m0_rdata = expire ? BUS_ERR_DATA : s_rdata;
            end
            StGrant1: begin
                grant    = 2'b10;
                s_valid  = m1_valid && !expire;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready || expire;
                m1_rdata = expire ? BUS_ERR_DATA : s_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout cases run when MEM_ARBITER_TIMEOUT_EN is set.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        reset_async;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_async (reset_async),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
        s_ready  = 1'b0; s_rdata = 32'd0;
    endtask

    task automatic do_reset();
        reset_async = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        reset_async = 1'b1;
        #1;
    endtask

    initial begin
        reset_async = 1'b0;
        idle_inputs();

        // Single m0 read, slave answers in the third grant cycle
        do_reset();
        check("rst_grant",  32'(grant),    32'd0);
        check("rst_svalid", 32'(s_valid),  32'd0);
        check("rst_err",    32'(err),      32'd0);
        check("rst_ready",  32'({m1_ready, m0_ready}), 32'd0);
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        m1_addr  = 32'hFFFF_0000;
        #1;
        check("idle_svalid", 32'(s_valid), 32'd0);
        check("idle_saddr",  s_addr,       32'd0);
        check("idle_grant",  32'(grant),   32'd0);
        cyc(); #1;
        check("g0_grant",  32'(grant),    32'd1);
        check("g0_svalid", 32'(s_valid),  32'd1);
        check("g0_saddr",  s_addr,        32'h0000_0010);
        check("g0_rdy_c1", 32'(m0_ready), 32'd0);
        cyc(); #1;
        check("g0_rdy_c2", 32'(m0_ready), 32'd0);
        cyc();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        check("g0_rdy_c3", 32'(m0_ready), 32'd1);
        check("g0_rdata",  m0_rdata,      32'h1234_5678);
        check("g0_m1rdy",  32'(m1_ready), 32'd0);
        check("g0_m1rd",   m1_rdata,      32'd0);
        cyc();
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'd0;
        #1;
        check("g0_done_grant", 32'(grant),    32'd0);
        check("g0_done_rdy",   32'(m0_ready), 32'd0);

        // Both masters continuously requesting: strict alternation via IDLE
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'hA000_0000;
        m1_valid = 1'b1; m1_addr = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("rr_idle", 32'(grant), 32'd0);
            cyc(); #1;
            check("rr_grant", 32'(grant), 32'(exp_g));
            check("rr_saddr", s_addr, (exp_g == 2'b01) ? 32'hA000_0000 : 32'hB000_0000);
            s_ready = 1'b1;
            #1;
            check("rr_ready", 32'({m1_ready, m0_ready}), 32'(exp_g));
            cyc();
            s_ready = 1'b0;
        end

        // Abort leaves the round-robin record untouched
        do_reset();
        m0_valid = 1'b1;
        cyc(); #1;
        check("ab_grant", 32'(grant), 32'd1);
        m0_valid = 1'b0;
        #1;
        check("ab_svalid", 32'(s_valid), 32'd0);
        cyc(); #1;
        check("ab_idle", 32'(grant), 32'd0);
        m0_valid = 1'b1; m1_valid = 1'b1;
        cyc(); #1;
        check("ab_rr", 32'(grant), 32'd1);

        // m0 waits behind an active m1 transfer
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wdata = 32'h0000_0055; m1_wstrb = 4'hF;
        cyc(); #1;
        check("w_grant1", 32'(grant),   32'd2);
        check("w_wstrb",  32'(s_wstrb), 32'hF);
        check("w_wdata",  s_wdata,      32'h0000_0055);
        m0_valid = 1'b1; m0_addr = 32'h0000_3000; m0_wstrb = 4'h0;
        #1;
        check("w_isolate", s_addr,        32'h0000_2000);
        check("w_m0rdy1",  32'(m0_ready), 32'd0);
        cyc(); #1;
        check("w_m0rdy2",  32'(m0_ready), 32'd0);
        check("w_grant1b", 32'(grant),    32'd2);
        cyc();
        s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
        #1;
        check("w_m1rdy",  32'(m1_ready), 32'd1);
        check("w_m1rd",   m1_rdata,      32'hA5A5_0001);
        check("w_m0rdy3", 32'(m0_ready), 32'd0);
        check("w_m0rd",   m0_rdata,      32'd0);
        cyc();
        m1_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("w_t1_idle", 32'(grant), 32'd0);
        cyc(); #1;
        check("w_t2_g0", 32'(grant),  32'd1);
        check("w_saddr", s_addr,      32'h0000_3000);
        s_ready = 1'b1;
        #1;
        check("w_m0done", 32'(m0_ready), 32'd1);
        cyc();
        idle_inputs();

        // Reset asserted mid-transfer: outputs drop at once, no ready
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0044;
        cyc(); #1;
        check("r_svalid_pre", 32'(s_valid), 32'd1);
        s_ready = 1'b1; s_rdata = 32'h0000_0099;
        reset_async = 1'b0;
        #1;
        check("r_svalid", 32'(s_valid), 32'd0);
        check("r_grant",  32'(grant),   32'd0);
        check("r_saddr",  s_addr,       32'd0);
        check("r_ready",  32'({m1_ready, m0_ready}), 32'd0);
        check("r_rdata",  m0_rdata,     32'd0);
        cyc(); #1;
        check("r_ready2", 32'(m0_ready), 32'd0);
        reset_async = 1'b1; s_ready = 1'b0;
        #1;
        cyc(); #1;
        check("r_regrant", 32'(grant), 32'd1);
        s_ready = 1'b1;
        cyc();
        idle_inputs();

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Slave never answers: bus-error completion in the 8th grant cycle
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_5000;
        for (int c = 1; c <= 7; c++) begin
            cyc(); #1;
            check("to_wait_rdy", 32'(m1_ready), 32'd0);
        end
        cyc(); #1;
        check("to_rdy",    32'(m1_ready), 32'd1);
        check("to_rdata",  m1_rdata,      BUS_ERR_DATA);
        check("to_svalid", 32'(s_valid),  32'd0);
        check("to_err_pre", 32'(err),     32'd0);
        cyc();
        m1_valid = 1'b0;
        #1;
        check("to_err",  32'(err),   32'd1);
        check("to_idle", 32'(grant), 32'd0);
        cyc(); cyc(); cyc(); #1;
        check("to_sticky", 32'(err), 32'd1);

        // s_ready in the expiry cycle wins over the timeout
        do_reset();
        check("tr_err_rst", 32'(err), 32'd0);
        m0_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
        end
        cyc();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        #1;
        check("tr_rdy",    32'(m0_ready), 32'd1);
        check("tr_rdata",  m0_rdata,      32'hCAFE_F00D);
        check("tr_svalid", 32'(s_valid),  32'd1);
        cyc();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("tr_err", 32'(err),   32'd0);
        check("tr_idle", 32'(grant), 32'd0);
`else
        // Without the watchdog a grant waits indefinitely
        do_reset();
        m1_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc(); #1;
            check("nt_wait_rdy", 32'(m1_ready), 32'd0);
        end
        check("nt_grant", 32'(grant), 32'd2);
        check("nt_err",   32'(err),   32'd0);
        s_ready = 1'b1; s_rdata = 32'h0000_0777;
        #1;
        check("nt_rdy",   32'(m1_ready), 32'd1);
        check("nt_rdata", m1_rdata,      32'h0000_0777);
        cyc();
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
